// File: rtl/peripheral_uart_tx.sv
// peripheral_uart_tx: bus-written byte FIFO feeding an 8N1 serialiser on a single TX pin.
// Latency: push at edge E0, FIFO pop and start bit at E1; each frame is 10*bit_div cycles.
// Backpressure: none on the bus; a push into a full FIFO is dropped and flags sticky overflow.
module peripheral_uart_tx #(
  parameter int DEFAULT_DIV = 868,
  parameter int FIFO_AW     = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] WD,
  input  logic        WE,
  output logic [31:0] RD,
  output logic        tx
);

  localparam int                DEPTH    = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0]  FULL_CNT = {1'b1, {FIFO_AW{1'b0}}};
  localparam logic [15:0]       DIV_RST  = 16'(DEFAULT_DIV);
  localparam logic [15:0]       DIV_MIN  = 16'd2;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  // Serialiser state
  logic [1:0]  state_q, state_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [15:0] bit_div_q, bit_div_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bitcnt_q, bitcnt_d;
  logic        tx_q, tx_d;

  // Configuration / status
  logic [15:0] div_q, div_d;
  logic        ovf_q, ovf_d;

  // Byte FIFO
  logic [7:0]         mem_q [DEPTH];
  logic [7:0]         mem_d [DEPTH];
  logic [FIFO_AW-1:0] wptr_q, wptr_d;
  logic [FIFO_AW-1:0] rptr_q, rptr_d;
  logic [FIFO_AW:0]   count_q, count_d;

  // Decoded bus strobes and FIFO flags
  logic        cfg_wr;
  logic        push_req;
  logic        push_ok;
  logic        pop;
  logic        fifo_empty;
  logic        fifo_full;
  logic        bit_end;
  logic [7:0]  rd_data;
  logic [15:0] wd_div;
  logic [4:0]  count_ext;
  logic        unused_wd;

  assign unused_wd = ^WD[30:16];

  // Bus write decode and FIFO status flags
  always_comb begin
    cfg_wr     = WE & WD[31];
    push_req   = WE & ~WD[31];
    wd_div     = WD[15:0];
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == FULL_CNT);
    rd_data    = mem_q[rptr_q];
    bit_end    = (baud_q == (bit_div_q - 16'd1));
  end

  // Frame sequencer: start bit, eight data bits LSB first, stop bit, chaining frames while data is queued
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_div_d = bit_div_q;
    baud_d    = baud_q;
    bitcnt_d  = bitcnt_q;
    pop       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          shreg_d   = rd_data;
          bit_div_d = div_q;
          baud_d    = '0;
          state_d   = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          baud_d   = '0;
          bitcnt_d = '0;
          state_d  = S_DATA;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          baud_d  = '0;
          shreg_d = {1'b0, shreg_q[7:1]};
          if (bitcnt_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bitcnt_d = bitcnt_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          baud_d = '0;
          if (!fifo_empty) begin
            // Next frame follows with no idle gap; the divisor is re-sampled here
            pop       = 1'b1;
            shreg_d   = rd_data;
            bit_div_d = div_q;
            state_d   = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Line level for the cycle after this edge, derived from the state being entered
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shreg_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  // FIFO bookkeeping: a push into a full FIFO still succeeds if a pop frees a slot on the same edge
  always_comb begin
    push_ok = push_req & (~fifo_full | pop);
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push_ok) begin
      mem_d[wptr_q] = WD[7:0];
      wptr_d        = wptr_q + FIFO_AW'(1'b1);
    end
    if (pop) begin
      rptr_d = rptr_q + FIFO_AW'(1'b1);
    end
    case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Configuration register and sticky overflow flag
  always_comb begin
    div_d = div_q;
    ovf_d = ovf_q;
    if (cfg_wr) begin
      div_d = (wd_div < DIV_MIN) ? DIV_MIN : wd_div;
      ovf_d = 1'b0;
    end else if (push_req && !push_ok) begin
      ovf_d = 1'b1;
    end
  end

  // Status word assembly
  always_comb begin
    count_ext              = '0;
    count_ext[FIFO_AW:0]   = count_q;
    RD = {(state_q != S_IDLE), fifo_full, fifo_empty, count_ext, ovf_q, 7'b0, div_q};
  end

  assign tx = tx_q;

  // Control registers; reset abandons any frame in flight and flushes the FIFO
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      shreg_q   <= '0;
      bit_div_q <= DIV_RST;
      baud_q    <= '0;
      bitcnt_q  <= '0;
      tx_q      <= 1'b1;
      div_q     <= DIV_RST;
      ovf_q     <= 1'b0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_div_q <= bit_div_d;
      baud_q    <= baud_d;
      bitcnt_q  <= bitcnt_d;
      tx_q      <= tx_d;
      div_q     <= div_d;
      ovf_q     <= ovf_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
    end
  end

  // FIFO storage needs no reset: the pointers and count define what is valid
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // The sequencer only pops when it has seen data queued
  assert property (@(posedge clk) disable iff (rst) !(pop && fifo_empty));
  // Occupancy can never exceed the FIFO depth
  assert property (@(posedge clk) disable iff (rst) count_q <= FULL_CNT);

endmodule

// File: tb/tb_peripheral_uart_tx.sv
// Bench for peripheral_uart_tx: directed scenarios plus random bus traffic.
// The reference tracks queued bytes and frame start times; the line level is derived arithmetically.
// Every cycle RD and tx are compared against the reference.
module tb_peripheral_uart_tx;

  localparam int DEFAULT_DIV = 868;
  localparam int FIFO_AW     = 3;
  localparam int DEPTH       = 1 << FIFO_AW;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] WD  = '0;
  logic        WE  = 1'b0;
  logic [31:0] RD;
  logic        tx;

  peripheral_uart_tx #(.DEFAULT_DIV(DEFAULT_DIV), .FIFO_AW(FIFO_AW)) dut (
    .clk (clk),
    .rst (rst),
    .WD  (WD),
    .WE  (WE),
    .RD  (RD),
    .tx  (tx)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: byte queue, config, and the active frame's start edge/divisor/byte
  logic [7:0]  mq[$];
  logic [15:0] m_div = 16'(DEFAULT_DIV);
  logic        m_ovf = 1'b0;
  logic        m_act = 1'b0;
  int          cyc   = 0;
  int          m_s   = 0;
  int          m_fd  = 1;
  logic [7:0]  m_fb  = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (edge %0d)", tag, got, exp, cyc);
    end
  endtask

  // Advance the reference by one clock edge using the inputs presented at that edge
  task automatic model_step();
    bit          frame_end;
    bit          do_pop;
    logic [15:0] old_div;
    cyc++;
    if (rst) begin
      mq.delete();
      m_ovf = 1'b0;
      m_div = 16'(DEFAULT_DIV);
      m_act = 1'b0;
      return;
    end
    frame_end = m_act && (cyc == m_s + 10 * m_fd);
    do_pop    = (frame_end || !m_act) && (mq.size() > 0);
    old_div   = m_div;
    if (frame_end) m_act = 1'b0;
    if (do_pop) begin
      m_fb  = mq.pop_front();
      m_act = 1'b1;
      m_s   = cyc;
      m_fd  = int'(old_div);
    end
    if (WE) begin
      if (WD[31]) begin
        m_div = (WD[15:0] < 16'd2) ? 16'd2 : WD[15:0];
        m_ovf = 1'b0;
      end else if (mq.size() < DEPTH) begin
        mq.push_back(WD[7:0]);
      end else begin
        m_ovf = 1'b1;
      end
    end
  endtask

  function automatic logic exp_tx();
    int idx;
    if (!m_act) return 1'b1;
    idx = (cyc - m_s) / m_fd;
    if (idx == 0) return 1'b0;
    if (idx >= 9) return 1'b1;
    return m_fb[idx-1];
  endfunction

  function automatic logic [31:0] exp_rd();
    return {m_act, (mq.size() == DEPTH), (mq.size() == 0), 5'(mq.size()),
            m_ovf, 7'b0, m_div};
  endfunction

  // One clock: update the reference on the edge, then compare just after it
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_eq("tx", {31'b0, tx}, {31'b0, exp_tx()});
    check_eq("rd", RD, exp_rd());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic push(input logic [7:0] b);
    WE = 1'b1;
    WD = {24'h0, b};
    cycle();
    WE = 1'b0;
    WD = '0;
  endtask

  task automatic cfg(input logic [15:0] d);
    WE = 1'b1;
    WD = {1'b1, 15'h0, d};
    cycle();
    WE = 1'b0;
    WD = '0;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n;
    n = 0;
    while ((m_act || mq.size() != 0) && n < budget) begin
      cycle();
      n++;
    end
    if (m_act || mq.size() != 0) check_eq(tag, 32'd0, 32'd1);
  endtask

  initial begin
    int  n;
    bit  need_cfg;
    int  r;

    // Reset values
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    check_eq("rst_rd", RD, 32'h2000_0364);
    check_eq("rst_tx", {31'b0, tx}, 32'd1);

    // Single frame at div=4
    cfg(16'd4);
    check_eq("div4_rd", {16'h0, RD[15:0]}, 32'd4);
    push(8'h55);
    idle(45);
    check_eq("single_busy", {31'b0, RD[31]}, 32'd0);

    // Divisor clamp
    cfg(16'd1);
    check_eq("div_clamp1", {16'h0, RD[15:0]}, 32'd2);
    cfg(16'd0);
    check_eq("div_clamp0", {16'h0, RD[15:0]}, 32'd2);

    // Back-to-back frames at div=2
    push(8'hA5);
    push(8'h3C);
    push(8'hFF);
    wait_drain("b2b_drain", 200);

    // Overflow with the serialiser busy
    cfg(16'd4);
    push(8'h01);
    idle(2);
    for (int i = 0; i < 9; i++) push(8'(8'h10 + i));
    check_eq("ovf_count", {27'h0, RD[28:24]}, 32'd8);
    check_eq("ovf_full",  {31'b0, RD[30]}, 32'd1);
    check_eq("ovf_flag",  {31'b0, RD[23]}, 32'd1);
    cfg(16'd4);
    check_eq("ovf_clear", {31'b0, RD[23]}, 32'd0);
    wait_drain("ovf_drain", 1000);

    // Push into a full FIFO on the exact pop edge
    cfg(16'd2);
    push(8'hC3);
    idle(1);
    for (int i = 0; i < 8; i++) push(8'(8'h80 + i));
    check_eq("pop_full", {31'b0, RD[30]}, 32'd1);
    n = 0;
    while (!(m_act && (cyc + 1 == m_s + 10 * m_fd)) && n < 200) begin
      cycle();
      n++;
    end
    if (n >= 200) check_eq("pop_edge_wait", 32'd0, 32'd1);
    push(8'h99);
    check_eq("pop_count", {27'h0, RD[28:24]}, 32'd8);
    check_eq("pop_ovf",   {31'b0, RD[23]}, 32'd0);
    wait_drain("pop_drain", 400);

    // Divisor change mid-frame
    cfg(16'd4);
    push(8'h6B);
    push(8'h92);
    idle(10);
    cfg(16'd6);
    wait_drain("middiv_drain", 400);

    // Reset during data bit 3 with two bytes queued
    cfg(16'd4);
    push(8'hE7);
    push(8'h18);
    push(8'h42);
    n = 0;
    while (!(m_act && ((cyc - m_s) / m_fd) == 4) && n < 200) begin
      cycle();
      n++;
    end
    if (n >= 200) check_eq("rstmid_wait", 32'd0, 32'd1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check_eq("rstmid_tx",    {31'b0, tx}, 32'd1);
    check_eq("rstmid_empty", {31'b0, RD[29]}, 32'd1);
    check_eq("rstmid_busy",  {31'b0, RD[31]}, 32'd0);
    idle(60);

    // Random bus traffic
    cfg(16'd3);
    need_cfg = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 999);
      WE = 1'b0;
      WD = '0;
      rst = 1'b0;
      if (need_cfg || r < 10) begin
        WE = 1'b1;
        WD = {1'b1, 15'($urandom), 16'($urandom_range(0, 7))};
        need_cfg = 1'b0;
      end else if (r < 12) begin
        rst = 1'b1;
        need_cfg = 1'b1;
      end else if (r < 100) begin
        WE = 1'b1;
        WD = {1'b0, 23'($urandom), 8'($urandom)};
      end
      cycle();
    end
    WE = 1'b0;
    WD = '0;
    rst = 1'b0;
    wait_drain("rand_drain", 1000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
